// File: rtl/security_pkg.sv
// Shared definitions for the intrusion alarm block.
//   DIST_W  : width of a distance sample in cm (unsigned)
//   STATE_W : width of the visible state encoding
//   state_e : alarm sequencer states and their fixed 3-bit encoding
package security_pkg;

  localparam int DIST_W  = 8;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   clr_i      : synchronous clear, restarts the count from 0 on the next edge
//   sec_tick_o : high for one cycle when the count reaches TICK_DIV-1
// With clr_i pulsed on the edge that enters a state, sec_tick_o is high in the
// cycle before edge entry+k*TICK_DIV, so a consumer acting on the tick leaves
// exactly k*TICK_DIV cycles after entry.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic sec_tick_o
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Not gated by clr_i: the FSM's expiry decision feeds clr_i, so gating
  // here would close a combinational loop.
  assign sec_tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/intrusion_alarm_fsm.sv
// Intrusion alarm sequencer fed by an ultrasonic ranging stage.
// Decides intrusion when HIT_COUNT consecutive valid samples lie in
// 0 < Distance_Raw < THRESH_CM, and sequences
// DISARMED -> EXIT_DELAY -> ARMED -> (ENTRY_DELAY) -> ALARM -> ARMED.
// Ports:
//   CLK          : system clock
//   RST          : asynchronous active-low reset
//   Distance_Raw : distance sample in cm, 0 = no echo
//   Dist_Valid   : one-cycle strobe qualifying Distance_Raw
//   Arm          : arm switch level, 0 forces DISARMED
//   LED_Armed    : high in every state except DISARMED
//   Pre_Warn     : high in ENTRY_DELAY
//   Alarm_Active : high in ALARM
//   Buzzer       : square wave in ALARM, starting high
//   State        : current state encoding
//   Alarm_Count  : ALARM entries since reset, saturating at 255
// Build option: define INTRUSION_ENTRY_DELAY_EN to include the ENTRY_DELAY
// pre-warning state; otherwise ARMED goes straight to ALARM and Pre_Warn is 0.
module intrusion_alarm_fsm
  import security_pkg::*;
#(
  parameter int THRESH_CM       = 50,
  parameter int HIT_COUNT       = 3,
  parameter int TICK_DIV        = 50_000_000,
  parameter int EXIT_DELAY_S    = 10,
  parameter int ENTRY_DELAY_S   = 5,
  parameter int ALARM_TIMEOUT_S = 60,
  parameter int BEEP_DIV        = 12_500_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIST_W-1:0]  Distance_Raw,
  input  logic               Dist_Valid,
  input  logic               Arm,
  output logic               LED_Armed,
  output logic               Pre_Warn,
  output logic               Alarm_Active,
  output logic               Buzzer,
  output logic [STATE_W-1:0] State,
  output logic [7:0]         Alarm_Count
);

  localparam int MAX_S_A = (EXIT_DELAY_S > ALARM_TIMEOUT_S) ? EXIT_DELAY_S : ALARM_TIMEOUT_S;
  localparam int MAX_S   = (MAX_S_A > ENTRY_DELAY_S) ? MAX_S_A : ENTRY_DELAY_S;
  localparam int SEC_W   = (MAX_S > 1) ? $clog2(MAX_S) : 1;
  localparam int HIT_W   = $clog2(HIT_COUNT + 1);
  localparam int BEEP_W  = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  localparam logic [SEC_W-1:0]  EXIT_LAST  = SEC_W'(EXIT_DELAY_S - 1);
  localparam logic [SEC_W-1:0]  ALARM_LAST = SEC_W'(ALARM_TIMEOUT_S - 1);
`ifdef INTRUSION_ENTRY_DELAY_EN
  localparam logic [SEC_W-1:0]  ENTRY_LAST = SEC_W'(ENTRY_DELAY_S - 1);
`endif
  localparam logic [HIT_W-1:0]  HIT_MAX    = HIT_W'(HIT_COUNT);
  localparam logic [HIT_W-1:0]  HIT_LAST   = HIT_W'(HIT_COUNT - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST  = BEEP_W'(BEEP_DIV - 1);
  localparam logic [DIST_W-1:0] THRESH     = DIST_W'(THRESH_CM);

  state_e            state_q;
  logic [SEC_W-1:0]  sec_cnt_q;
  logic [HIT_W-1:0]  hit_cnt_q;
  logic [BEEP_W-1:0] beep_cnt_q;
  logic              buzzer_q;
  logic              led_q;
  logic              alarm_q;
  logic [7:0]        alarm_cnt_q;
`ifdef INTRUSION_ENTRY_DELAY_EN
  logic              pre_warn_q;
`endif

  logic sec_tick;
  logic tick_clr;
  logic in_range;
  logic timed_last;
  logic expire;
  logic qualify;

  always_comb begin
    in_range   = (Distance_Raw != '0) && (Distance_Raw < THRESH);
    timed_last = 1'b0;
    case (state_q)
      ST_EXIT_DELAY:  timed_last = (sec_cnt_q == EXIT_LAST);
`ifdef INTRUSION_ENTRY_DELAY_EN
      ST_ENTRY_DELAY: timed_last = (sec_cnt_q == ENTRY_LAST);
`endif
      ST_ALARM:       timed_last = (sec_cnt_q == ALARM_LAST);
      default:        timed_last = 1'b0;
    endcase
    expire  = sec_tick && timed_last;
    // The strobe that brings the counter to HIT_COUNT triggers the move.
    qualify = (state_q == ST_ARMED) && Dist_Valid && in_range && (hit_cnt_q >= HIT_LAST);
    // Restart the prescaler on every edge that changes state (clearing it
    // while DISARMED or while Arm is low is harmless).
    tick_clr = !Arm || (state_q == ST_DISARMED) || expire || qualify;
  end

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .clr_i      (tick_clr),
    .sec_tick_o (sec_tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_DISARMED;
      sec_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      beep_cnt_q  <= '0;
      buzzer_q    <= 1'b0;
      led_q       <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
`ifdef INTRUSION_ENTRY_DELAY_EN
      pre_warn_q  <= 1'b0;
`endif
    end else if (!Arm) begin
      // Disarm wins over every other event; the alarm tally is kept.
      state_q    <= ST_DISARMED;
      sec_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      beep_cnt_q <= '0;
      buzzer_q   <= 1'b0;
      led_q      <= 1'b0;
      alarm_q    <= 1'b0;
`ifdef INTRUSION_ENTRY_DELAY_EN
      pre_warn_q <= 1'b0;
`endif
    end else begin
      if (sec_tick) begin
        sec_cnt_q <= sec_cnt_q + SEC_W'(1);
      end
      case (state_q)
        ST_DISARMED: begin
          state_q   <= ST_EXIT_DELAY;
          led_q     <= 1'b1;
          sec_cnt_q <= '0;
          hit_cnt_q <= '0;
        end
        ST_EXIT_DELAY: begin
          hit_cnt_q <= '0;
          if (expire) begin
            state_q   <= ST_ARMED;
            sec_cnt_q <= '0;
          end
        end
        ST_ARMED: begin
          sec_cnt_q <= '0;
          if (Dist_Valid) begin
            if (in_range) begin
              if (hit_cnt_q != HIT_MAX) begin
                hit_cnt_q <= hit_cnt_q + HIT_W'(1);
              end
            end else if (Distance_Raw >= THRESH) begin
              hit_cnt_q <= '0;
            end
          end
          if (qualify) begin
            hit_cnt_q <= '0;
`ifdef INTRUSION_ENTRY_DELAY_EN
            state_q    <= ST_ENTRY_DELAY;
            pre_warn_q <= 1'b1;
`else
            state_q    <= ST_ALARM;
            alarm_q    <= 1'b1;
            buzzer_q   <= 1'b1;
            beep_cnt_q <= '0;
            if (alarm_cnt_q != 8'hFF) begin
              alarm_cnt_q <= alarm_cnt_q + 8'd1;
            end
`endif
          end
        end
`ifdef INTRUSION_ENTRY_DELAY_EN
        ST_ENTRY_DELAY: begin
          if (expire) begin
            state_q    <= ST_ALARM;
            sec_cnt_q  <= '0;
            pre_warn_q <= 1'b0;
            alarm_q    <= 1'b1;
            buzzer_q   <= 1'b1;
            beep_cnt_q <= '0;
            if (alarm_cnt_q != 8'hFF) begin
              alarm_cnt_q <= alarm_cnt_q + 8'd1;
            end
          end
        end
`endif
        ST_ALARM: begin
          if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_q <= '0;
            buzzer_q   <= ~buzzer_q;
          end else begin
            beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
          end
          if (expire) begin
            state_q    <= ST_ARMED;
            sec_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            alarm_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            beep_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_DISARMED;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign LED_Armed    = led_q;
  assign Alarm_Active = alarm_q;
  assign Buzzer       = buzzer_q;
  assign State        = state_q;
  assign Alarm_Count  = alarm_cnt_q;
`ifdef INTRUSION_ENTRY_DELAY_EN
  assign Pre_Warn     = pre_warn_q;
`else
  assign Pre_Warn     = 1'b0;
`endif

endmodule

// File: tb/tb_intrusion_alarm_fsm.sv
module tb_intrusion_alarm_fsm;

`ifdef INTRUSION_ENTRY_DELAY_EN
  localparam bit ENTRY_EN = 1'b1;
`else
  localparam bit ENTRY_EN = 1'b0;
`endif
  // Cycles spent in ENTRY_DELAY (1 s * 10 cycles) when present.
  localparam int ED = ENTRY_EN ? 10 : 0;
  localparam logic [2:0] ST_Q = ENTRY_EN ? 3'd3 : 3'd4;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] Distance_Raw;
  logic       Dist_Valid;
  logic       Arm;
  logic       LED_Armed, Pre_Warn, Alarm_Active, Buzzer;
  logic [2:0] State;
  logic [7:0] Alarm_Count;

  intrusion_alarm_fsm #(
    .THRESH_CM       (50),
    .HIT_COUNT       (3),
    .TICK_DIV        (10),
    .EXIT_DELAY_S    (2),
    .ENTRY_DELAY_S   (1),
    .ALARM_TIMEOUT_S (3),
    .BEEP_DIV        (2)
  ) dut (
    .CLK          (clk),
    .RST          (RST),
    .Distance_Raw (Distance_Raw),
    .Dist_Valid   (Dist_Valid),
    .Arm          (Arm),
    .LED_Armed    (LED_Armed),
    .Pre_Warn     (Pre_Warn),
    .Alarm_Active (Alarm_Active),
    .Buzzer       (Buzzer),
    .State        (State),
    .Alarm_Count  (Alarm_Count)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         at;
    string      nm;
    logic [2:0] st;
    logic       led, pw, aa, bz;
    logic [7:0] cnt;
    bit         chk_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: outputs are registered, so each expectation is tagged with the
  // edge after which it must hold and compared on the following negedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    while (sb_q.size() != 0 && sb_q[0].at <= edge_cnt) begin
      e  = sb_q.pop_front();
      ok = (e.at == edge_cnt) && (State === e.st) && (LED_Armed === e.led) &&
           (Pre_Warn === e.pw) && (Alarm_Active === e.aa) && (Buzzer === e.bz) &&
           (!e.chk_cnt || (Alarm_Count === e.cnt));
      n_checks++;
      if (ok) begin
        n_pass++;
        $display("ok   %-18s edge %0d st=%0d led=%b pw=%b aa=%b bz=%b cnt=%0d",
                 e.nm, edge_cnt, State, LED_Armed, Pre_Warn, Alarm_Active, Buzzer, Alarm_Count);
      end else begin
        $display("FAIL %s edge %0d (due %0d): got st=%0d led=%b pw=%b aa=%b bz=%b cnt=%0d, want st=%0d led=%b pw=%b aa=%b bz=%b cnt=%0d",
                 e.nm, edge_cnt, e.at, State, LED_Armed, Pre_Warn, Alarm_Active, Buzzer, Alarm_Count,
                 e.st, e.led, e.pw, e.aa, e.bz, e.cnt);
      end
    end
  end

  task automatic expect_out(input int at, input string nm, input logic [2:0] st,
                            input logic led, input logic pw, input logic aa,
                            input logic bz, input logic [7:0] cnt, input bit chk_cnt);
    exp_t e;
    e.at = at; e.nm = nm; e.st = st; e.led = led; e.pw = pw; e.aa = aa;
    e.bz = bz; e.cnt = cnt; e.chk_cnt = chk_cnt;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_edge(input int e);
    while (edge_cnt < e) step(1);
  endtask

  task automatic strobe(input logic [7:0] d);
    Distance_Raw = d;
    Dist_Valid   = 1'b1;
    step(1);
    Dist_Valid   = 1'b0;
  endtask

  // Buzzer level k cycles after ALARM entry with BEEP_DIV=2.
  function automatic logic bz_at(input int k);
    return ((k / 2) % 2) == 0;
  endfunction

  int a, A, q, e_al, B, e2, C, q3, e3, D1;
  int ks[6] = '{0, 1, 2, 3, 4, 29};

  initial begin
    RST = 1'b0; Arm = 1'b0; Dist_Valid = 1'b0; Distance_Raw = 8'd0;
    step(2);
    expect_out(edge_cnt, "reset", 3'd0, 0, 0, 0, 0, 8'd0, 1);
    RST = 1'b1; Arm = 1'b1;

    // Arming and exit delay; strobes during exit delay must be ignored.
    a = edge_cnt + 1;
    expect_out(a,      "exit_entry", 3'd1, 1, 0, 0, 0, 8'd0, 1);
    expect_out(a + 19, "exit_last",  3'd1, 1, 0, 0, 0, 8'd0, 1);
    expect_out(a + 20, "armed",      3'd2, 1, 0, 0, 0, 8'd0, 1);
    goto_edge(a + 4);
    strobe(8'd20); strobe(8'd20); strobe(8'd20);
    goto_edge(a + 20);

    // Scenario 1: 30,40,20 then alarm and timeout.
    A = edge_cnt; q = A + 3; e_al = q + ED;
    expect_out(A + 1, "s1_one_hit",  3'd2, 1, 0, 0, 0, 8'd0, 1);
    expect_out(A + 2, "s1_two_hits", 3'd2, 1, 0, 0, 0, 8'd0, 1);
    expect_out(q, "s1_qualify", ST_Q, 1, ENTRY_EN, !ENTRY_EN, !ENTRY_EN,
               ENTRY_EN ? 8'd0 : 8'd1, 1);
    foreach (ks[i])
      expect_out(e_al + ks[i], "s1_alarm", 3'd4, 1, 0, 1, bz_at(ks[i]), 8'd1, 1);
    expect_out(e_al + 30, "s1_rearm", 3'd2, 1, 0, 0, 0, 8'd1, 1);
    strobe(8'd30); strobe(8'd40); strobe(8'd20);
    goto_edge(e_al + 30);

    // Scenario 2: threshold boundary and a far sample clearing the count.
    B = edge_cnt; e2 = B + 9 + ED; C = e2 + 30;
    expect_out(B + 3, "s2_thresh_eq", 3'd2, 1, 0, 0, 0, 8'd1, 1);
    expect_out(B + 8, "s2_cleared",   3'd2, 1, 0, 0, 0, 8'd1, 1);
    expect_out(B + 9, "s2_qualify", ST_Q, 1, ENTRY_EN, !ENTRY_EN, !ENTRY_EN,
               ENTRY_EN ? 8'd1 : 8'd2, 1);
    expect_out(e2,    "s2_alarm",     3'd4, 1, 0, 1, 1, 8'd2, 1);
    expect_out(C,     "s2_rearm",     3'd2, 1, 0, 0, 0, 8'd2, 1);
    strobe(8'd49); strobe(8'd49); strobe(8'd50);
    strobe(8'd30); strobe(8'd40); strobe(8'd80); strobe(8'd30); strobe(8'd40);
    strobe(8'd20);
    goto_edge(C - 1);
    strobe(8'd20);  // coincides with the ALARM expiry edge: ignored

    // Scenario 3: zeros ignored.
    q3 = C + 5; e3 = q3 + ED;
    expect_out(C + 3, "s3_no_early",  3'd2, 1, 0, 0, 0, 8'd2, 1);
    expect_out(C + 4, "s3_zero_ign",  3'd2, 1, 0, 0, 0, 8'd2, 1);
    expect_out(q3, "s3_qualify", ST_Q, 1, ENTRY_EN, !ENTRY_EN, !ENTRY_EN,
               ENTRY_EN ? 8'd2 : 8'd3, 1);
    expect_out(e3,    "s3_alarm",     3'd4, 1, 0, 1, 1, 8'd3, 1);
    strobe(8'd30); strobe(8'd0); strobe(8'd40); strobe(8'd0); strobe(8'd20);

    // Disarm in ALARM together with a strobe.
    goto_edge(e3 + 4);
    expect_out(e3 + 5, "disarm_alarm", 3'd0, 0, 0, 0, 0, 8'd0, 0);
    Arm = 1'b0; Distance_Raw = 8'd20; Dist_Valid = 1'b1;
    step(1);
    Dist_Valid = 1'b0; Arm = 1'b1;
    D1 = edge_cnt + 1;
    expect_out(D1,     "rearm_exit",  3'd1, 1, 0, 0, 0, 8'd3, 1);
    expect_out(D1 + 4, "exit_hold",   3'd1, 1, 0, 0, 0, 8'd3, 1);
    goto_edge(D1 + 5);

    // Asynchronous reset mid exit delay.
    RST = 1'b0;
    expect_out(edge_cnt,     "rst_mid",  3'd0, 0, 0, 0, 0, 8'd0, 1);
    expect_out(edge_cnt + 1, "rst_hold", 3'd0, 0, 0, 0, 0, 8'd0, 1);
    step(1);
    RST = 1'b1;
    expect_out(edge_cnt + 1, "post_rst", 3'd1, 1, 0, 0, 0, 8'd0, 1);
    step(2);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
